// File: rtl/kogge_serial_adder_pkg.sv
// Shared types for the serial Kogge-Stone adder: slice width and sequencer states.
package adder_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addseq_state_t;
endpackage

// File: rtl/kogge_slice4.sv
// Combinational 4-bit Kogge-Stone adder slice with a full-prefix carry-out.
module kogge_slice4
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_cout
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_g0;
  logic [3:0] w_g1;
  logic [3:2] w_p1;
  logic [3:0] w_g2;
  logic [3:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Carry-in is folded into bit 0's generate, so every group generate below is a carry.
  assign w_g0 = {w_g[3:1], w_g[0] | (w_p[0] & i_cin)};

  assign w_g1[0] = w_g0[0];
  assign w_g1[1] = w_g0[1] | (w_p[1] & w_g0[0]);
  assign w_g1[2] = w_g0[2] | (w_p[2] & w_g0[1]);
  assign w_g1[3] = w_g0[3] | (w_p[3] & w_g0[2]);
  assign w_p1    = {w_p[3] & w_p[2], w_p[2] & w_p[1]};

  assign w_g2[1:0] = w_g1[1:0];
  assign w_g2[2]   = w_g1[2] | (w_p1[2] & w_g1[0]);
  assign w_g2[3]   = w_g1[3] | (w_p1[3] & w_g1[1]);

  assign w_c    = {w_g2[2:0], i_cin};
  assign o_s    = w_p ^ w_c;
  assign o_cout = w_g2[3];
endmodule

// File: rtl/kogge_serial_adder.sv
// Multi-cycle WIDTH-bit adder feeding one 4-bit Kogge-Stone slice per cycle.
// Define KOGGE_SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b via ~b and carry-in 1).
module kogge_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                cin,
`ifdef KOGGE_SERIAL_ADDER_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    sum,
  output logic                cout,
  output logic                busy,
  output addseq_state_t       dbg_state
);
  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("kogge_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  addseq_state_t      r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;

  logic [SLICE_W-1:0] w_s;
  logic               w_cout;
  logic [WIDTH-1:0]   w_ins;
  logic               w_sub;
  logic [WIDTH-1:0]   w_b_eff;
  logic               w_cin_eff;

`ifdef KOGGE_SERIAL_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif
  assign w_b_eff   = w_sub ? ~b : b;
  assign w_cin_eff = w_sub ? 1'b1 : cin;

  kogge_slice4 u_slice (
    .i_a    (r_a[SLICE_W-1:0]),
    .i_b    (r_b[SLICE_W-1:0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  assign w_ins = WIDTH'(w_s) << (WIDTH - SLICE_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> SLICE_W;
          r_b     <= r_b >> SLICE_W;
          r_sum   <= (r_sum >> SLICE_W) | w_ins;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_carry;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_kogge_serial_adder.sv
// Directed and random checks of kogge_serial_adder at WIDTH=16 and WIDTH=4.
module tb_kogge_serial_adder;
  import adder_pkg::*;

  localparam int W  = 16;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, cin, out_valid, out_ready, cout, busy, sub;
  logic [W-1:0]  a16, b16, sum;
  addseq_state_t st16;

  logic          in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4, sub4;
  logic [W4-1:0] a4, b4, sum4;
  addseq_state_t st4;

  logic [W:0]  exp_q[$];
  logic [W4:0] exp4_q[$];
  int total = 0;
  int bad   = 0;

  kogge_serial_adder #(.WIDTH(W)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a16), .b(b16), .cin(cin),
`ifdef KOGGE_SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .busy(busy), .dbg_state(st16)
  );

  kogge_serial_adder #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
`ifdef KOGGE_SERIAL_ADDER_SUB_EN
    .sub(sub4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4),
    .busy(busy4), .dbg_state(st4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sub_eff(input logic s);
`ifdef KOGGE_SERIAL_ADDER_SUB_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  task automatic send16(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    a16 = ta; b16 = tb; cin = tc; sub = ts; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("accept16_timeout", 64'(n < 100), 64'd1);
    if (sub_eff(ts)) exp_q.push_back({1'b0, ta} + {1'b0, ~tb} + (W+1)'(1));
    else             exp_q.push_back({1'b0, ta} + {1'b0, tb} + (W+1)'(tc));
    @(negedge clk);
    in_valid = 1'b0;
    a16 = W'($urandom); b16 = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic recv16(input int maxgap);
    int n = 0;
    logic done = 1'b0;
    logic [W:0] e;
    while (!done && n < 200) begin
      out_ready = ($urandom_range(0, maxgap) == 0);
      if (out_valid && out_ready) begin
        check("q16_nonempty", 64'(exp_q.size() > 0), 64'd1);
        e = exp_q.pop_front();
        check("sum16", 64'(sum), 64'(e[W-1:0]));
        check("cout16", 64'(cout), 64'(e[W]));
        done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    check("recv16_timeout", 64'(done), 64'd1);
    check("ov16_drop", 64'(out_valid), 64'd0);
  endtask

  task automatic send4(input logic [W4-1:0] ta, input logic [W4-1:0] tb, input logic tc,
                       input logic ts, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    a4 = ta; b4 = tb; cin4 = tc; sub4 = ts; in_valid4 = 1'b1;
    while (!in_ready4 && n < 100) begin @(negedge clk); n++; end
    check("accept4_timeout", 64'(n < 100), 64'd1);
    if (sub_eff(ts)) exp4_q.push_back({1'b0, ta} + {1'b0, ~tb} + (W4+1)'(1));
    else             exp4_q.push_back({1'b0, ta} + {1'b0, tb} + (W4+1)'(tc));
    @(negedge clk);
    in_valid4 = 1'b0;
    a4 = W4'($urandom); b4 = W4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
  endtask

  task automatic recv4(input int maxgap);
    int n = 0;
    logic done = 1'b0;
    logic [W4:0] e;
    while (!done && n < 200) begin
      out_ready4 = ($urandom_range(0, maxgap) == 0);
      if (out_valid4 && out_ready4) begin
        check("q4_nonempty", 64'(exp4_q.size() > 0), 64'd1);
        e = exp4_q.pop_front();
        check("sum4", 64'(sum4), 64'(e[W4-1:0]));
        check("cout4", 64'(cout4), 64'(e[W4]));
        done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    out_ready4 = 1'b0;
    check("recv4_timeout", 64'(done), 64'd1);
    check("ov4_drop", 64'(out_valid4), 64'd0);
  endtask

  initial begin
    logic [W:0] e;
    int n;
    rst = 1'b1;
    in_valid = 0; a16 = '0; b16 = '0; cin = 0; sub = 0; out_ready = 0;
    in_valid4 = 0; a4 = '0; b4 = '0; cin4 = 0; sub4 = 0; out_ready4 = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_state", 64'(st16), 64'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // 1: basic add and exact latency (accept edge T, out_valid after edge T+4)
    send16(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
    check("lat_t0", 64'(out_valid), 64'd0);
    check("busy_run", 64'(busy), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("lat_early", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check("lat_t4", 64'(out_valid), 64'd1);
    check("t1_sum", 64'(sum), 64'h2233);
    recv16(0);

    // 2: carry ripples through every nibble
    send16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
    recv16(0);

    // 3: backpressure holds the result
    send16(16'hABCD, 16'h1111, 1'b1, 1'b0, 0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_wait", 64'(out_valid), 64'd1);
    e = exp_q[0];
    repeat (5) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_sum", 64'(sum), 64'(e[W-1:0]));
      check("bp_cout", 64'(cout), 64'(e[W]));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    recv16(0);
    check("bp_in_ready_after", 64'(in_ready), 64'd1);

    // 4: reset mid-RUN loses the op
    send16(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    send16(16'h00FF, 16'h0001, 1'b0, 1'b0, 1);
    recv16(0);

`ifdef KOGGE_SERIAL_ADDER_SUB_EN
    // 5: subtraction
    send16(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    recv16(0);
    send16(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
    recv16(0);
`endif

    // 6: random traffic on both widths
    for (int i = 0; i < 500; i++) begin
      send16(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
      recv16(3);
    end
    send4(4'hF, 4'h0, 1'b1, 1'b0, 0);
    recv4(0);
    for (int i = 0; i < 500; i++) begin
      send4(W4'($urandom), W4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
      recv4(3);
    end
    check("q16_empty", 64'(exp_q.size()), 64'd0);
    check("q4_empty", 64'(exp4_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
